// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial packed-BCD adder, one digit per clock, LSD first
// Optional BCD_SUB_EN adds a sub port selecting A-B via nines complement of B.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r, b_eff, sum_r;
  logic [IDXW-1:0] idx;
  logic            carry, carry_init, cout_r, err_r, err_in;
  logic [3:0]      a_dig, b_dig, s_dig;
  logic [4:0]      d;
  logic            c_nx;
  logic            accept;

  assign accept = in_valid & in_ready;

  // Subtraction folds into addition: nines complement of B plus a forced carry-in.
  always_comb begin
    b_eff      = b;
    carry_init = cin;
`ifdef BCD_SUB_EN
    if (sub) begin
      for (int i = 0; i < DIGITS; i++) begin
        b_eff[4*i +: 4] = 4'd9 - b[4*i +: 4];
      end
      carry_init = 1'b1;
    end
`endif
  end

  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
        err_in = 1'b1;
      end
    end
  end

  // One decimal digit of the ripple; invalid digits go through the same rule.
  always_comb begin
    a_dig = a_r[4*idx +: 4];
    b_dig = b_r[4*idx +: 4];
    d     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
    if (d > 5'd9) begin
      s_dig = d[3:0] + 4'd6;
      c_nx  = 1'b1;
    end else begin
      s_dig = d[3:0];
      c_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (idx == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= a;
            b_r   <= b_eff;
            carry <= carry_init;
            idx   <= '0;
            err_r <= err_in;
          end
        end
        RUN: begin
          sum_r[4*idx +: 4] <= s_dig;
          carry             <= c_nx;
          if (idx == LAST) begin
            cout_r <= c_nx;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign err  = err_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - scoreboard bench for bcd_serial_adder with DIGITS=4
// Define BCD_SUB_EN to also exercise subtraction.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef BCD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef BCD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Drives one operand pair at a negedge, accepts it on the next posedge, records the expectation.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic ee);
    exp_t e;
    e.sum = es; e.cout = ec; e.err = ee;
    sb.push_back(e);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid (starting at the negedge right after acceptance) and scores the result.
  task automatic wait_result(input string tag);
    int   edges;
    exp_t e;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, "_latency"}, edges, DIGITS);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"},  {16'b0, sum}, {16'b0, e.sum});
      chk({tag, "_cout"}, {31'b0, cout}, {31'b0, e.cout});
      chk({tag, "_err"},  {31'b0, err},  {31'b0, e.err});
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_in_ready_back"},  {31'b0, in_ready},  32'd1);
  endtask

  initial begin
    int ra, rb, rc, tot;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef BCD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum",       {16'b0, sum},       32'd0);
    chk("rst_cout",      {31'b0, cout},      32'd0);
    chk("rst_err",       {31'b0, err},       32'd0);

    start_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    wait_result("add_1234_5678");
    handshake("add_1234_5678");

    start_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_result("ripple_9999_0001");
    handshake("ripple_9999_0001");

    start_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    wait_result("max_9999_9999_c1");
    handshake("max_9999_9999_c1");

    // Digit 0xA: 10 > 9 gives digit 0 with carry into the next digit.
    start_op(16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, 1'b1);
    wait_result("invalid_digit");
    handshake("invalid_digit");

    start_op(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0);
    wait_result("hold");
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1);
      a = 16'h1111; b = 16'h1111;
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready",  {31'b0, in_ready},  32'd0);
      chk("hold_sum",       {16'b0, sum},       32'h0100);
      chk("hold_cout",      {31'b0, cout},      32'd0);
    end
    in_valid = 1'b1;
    handshake("hold");
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("dropped_no_result", {31'b0, out_valid}, 32'd0);
    chk("dropped_idle",      {31'b0, in_ready},  32'd1);
    chk("dropped_sum_kept",  {16'b0, sum},       32'h0100);

    // Abort mid-RUN at digit index 2.
    a = 16'h4321; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_sum",       {16'b0, sum},       32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_result", {31'b0, out_valid}, 32'd0);

    for (int n = 0; n < 6; n++) begin
      ra = $urandom_range(0, 9999);
      rb = $urandom_range(0, 9999);
      rc = $urandom_range(0, 1);
      tot = ra + rb + rc;
      start_op(to_bcd(ra), to_bcd(rb), rc[0], to_bcd(tot % 10000), (tot >= 10000), 1'b0);
      wait_result("rand_add");
      handshake("rand_add");
    end

`ifdef BCD_SUB_EN
    sub = 1'b1;
    start_op(16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b1, 1'b0);
    wait_result("sub_5000_1234");
    handshake("sub_5000_1234");
    start_op(16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b0);
    wait_result("sub_1234_5000");
    handshake("sub_1234_5000");
    sub = 1'b0;
`endif

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
